// File: rtl/rx_pkg.sv
// Shared constants for the UART receive-side byte buffer.
package rx_pkg;

    localparam int unsigned RX_DATA_W     = 8;
    localparam int unsigned RX_FIFO_DEPTH = 8;
    localparam logic [RX_DATA_W-1:0] RX_IDLE_BYTE = '1;

endpackage

// File: rtl/rx_fifo_if.sv
// Push/pop handshake bundle between the receiver controller, the host and rx_fifo.
interface rx_fifo_if
    import rx_pkg::*;
#(
    parameter int unsigned DEPTH  = RX_FIFO_DEPTH,
    parameter int unsigned DATA_W = RX_DATA_W
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              load_buffer;
    logic [DATA_W-1:0] packet_data;
    logic              data_read;
    logic [DATA_W-1:0] rx_data;
    logic              data_ready;
    logic              overrun_error;
    logic [CNT_W-1:0]  count;

    modport master (
        output load_buffer, packet_data, data_read,
        input  rx_data, data_ready, overrun_error, count
    );

    modport slave (
        input  load_buffer, packet_data, data_read,
        output rx_data, data_ready, overrun_error, count
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter; wraps naturally because the depth is a power of two.
module fifo_ptr #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + W'(1);
    end

endmodule

// File: rtl/rx_fifo.sv
// Receive byte FIFO: show-ahead read port, count-based full/empty, sticky overrun flag.
module rx_fifo
    import rx_pkg::*;
#(
    parameter int unsigned DEPTH  = RX_FIFO_DEPTH,
    parameter int unsigned DATA_W = RX_DATA_W
) (
    input  logic       clk,
    input  logic       rst,
    rx_fifo_if.slave   bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              overrun;
    logic              empty_c;
    logic              full_c;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
    always_comb begin
        empty_c = (count == '0);
        full_c  = (count == CNT_W'(DEPTH));
        pop_c   = bus.data_read && !empty_c;
        push_c  = bus.load_buffer && (!full_c || pop_c);
        drop_c  = bus.load_buffer && full_c && !pop_c;
    end

    fifo_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_c),
        .ptr (rd_ptr)
    );

    fifo_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_c),
        .ptr (wr_ptr)
    );

    // Storage is deliberately left unreset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (push_c)
            mem[wr_ptr] <= bus.packet_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (push_c && !pop_c)
            count <= count + CNT_W'(1);
        else if (pop_c && !push_c)
            count <= count - CNT_W'(1);
    end

    // Any read strobe acknowledges the flag; a read while full is a pop, so no set/clear clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else if (drop_c)
            overrun <= 1'b1;
        else if (bus.data_read)
            overrun <= 1'b0;
    end

    assign bus.rx_data       = empty_c ? {DATA_W{1'b1}} : mem[rd_ptr];
    assign bus.data_ready    = !empty_c;
    assign bus.overrun_error = overrun;
    assign bus.count         = count;

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_rx_fifo;
    import rx_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0] q[$];
    logic       ovr_m;

    rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(8)) bus ();

    rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_rx();
        return (q.size() > 0) ? q[0] : 8'hFF;
    endfunction

    // One clock with the given strobes; the model follows the FIFO rules on the same edge.
    task automatic cycle(input logic ld, input logic [7:0] d, input logic rd);
        bit pop, push;
        bus.load_buffer = ld;
        bus.packet_data = d;
        bus.data_read   = rd;
        @(posedge clk);
        pop  = rd && (q.size() > 0);
        push = ld && ((q.size() < DEPTH) || pop);
        if (ld && q.size() == DEPTH && !pop) ovr_m = 1'b1;
        else if (rd)                         ovr_m = 1'b0;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(d);
        #1;
        bus.load_buffer = 1'b0;
        bus.data_read   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.load_buffer = 1'b0;
        bus.packet_data = 8'h00;
        bus.data_read   = 1'b0;
        q.delete();
        ovr_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.data_ready); end
        checks++; if (bus.rx_data !== RX_IDLE_BYTE) begin errors++; $display("FAIL reset_rx got %h exp ff", bus.rx_data); end
        checks++; if (bus.overrun_error !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", bus.overrun_error); end
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (bus.count !== 4'd0 || bus.data_ready !== 1'b0 || bus.rx_data !== 8'hFF)
            begin errors++; $display("FAIL idle_read got cnt=%0d rdy=%b rx=%h exp 0 0 ff", bus.count, bus.data_ready, bus.rx_data); end
    endtask

    task automatic test_single();
        cycle(1'b1, 8'hA5, 1'b0);
        checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx got %h exp a5", bus.rx_data); end
        checks++; if (bus.data_ready !== 1'b1 || bus.count !== 4'd1)
            begin errors++; $display("FAIL single_state got rdy=%b cnt=%0d exp 1 1", bus.data_ready, bus.count); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (bus.data_ready !== 1'b0 || bus.rx_data !== 8'hFF)
            begin errors++; $display("FAIL single_pop got rdy=%b rx=%h exp 0 ff", bus.data_ready, bus.rx_data); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(8'h01 + i), 1'b0);
            checks++; if (bus.count !== 4'(i + 1)) begin errors++; $display("FAIL wrap_fill_count got %0d exp %0d", bus.count, i + 1); end
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.rx_data !== 8'(8'h01 + i) || bus.count !== 4'(8 - i))
                begin errors++; $display("FAIL wrap_drain got rx=%h cnt=%0d exp %h %0d", bus.rx_data, bus.count, 8'(8'h01 + i), 8 - i); end
            cycle(1'b0, 8'h00, 1'b1);
        end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL wrap_empty got %0d exp 0", bus.count); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(8'h09 + i), 1'b0);
            checks++; if (bus.rx_data !== 8'(8'h09 + i)) begin errors++; $display("FAIL wrap_pass got %h exp %h", bus.rx_data, 8'(8'h09 + i)); end
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL wrap_pass_empty got %b exp 0", bus.data_ready); end
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
        checks++; if (bus.overrun_error !== 1'b0) begin errors++; $display("FAIL ovr_pre got %b exp 0", bus.overrun_error); end
        cycle(1'b1, 8'h99, 1'b0);
        checks++; if (bus.overrun_error !== 1'b1 || bus.count !== 4'd8)
            begin errors++; $display("FAIL ovr_set got ovr=%b cnt=%0d exp 1 8", bus.overrun_error, bus.count); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.rx_data !== 8'(8'h10 + i))
                begin errors++; $display("FAIL ovr_drain got %h exp %h", bus.rx_data, 8'(8'h10 + i)); end
            cycle(1'b0, 8'h00, 1'b1);
            if (i == 0) begin
                checks++; if (bus.overrun_error !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", bus.overrun_error); end
            end
        end
        checks++; if (bus.rx_data !== 8'hFF || bus.count !== 4'd0)
            begin errors++; $display("FAIL ovr_dropped got rx=%h cnt=%0d exp ff 0", bus.rx_data, bus.count); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        checks++; if (bus.overrun_error !== 1'b0 || bus.count !== 4'd8)
            begin errors++; $display("FAIL simul_full got ovr=%b cnt=%0d exp 0 8", bus.overrun_error, bus.count); end
        checks++; if (bus.rx_data !== 8'h21) begin errors++; $display("FAIL simul_full_head got %h exp 21", bus.rx_data); end
        for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
        checks++; if (bus.rx_data !== 8'h55 || bus.count !== 4'd1)
            begin errors++; $display("FAIL simul_last got rx=%h cnt=%0d exp 55 1", bus.rx_data, bus.count); end
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h66, 1'b1);
        checks++; if (bus.count !== 4'd1 || bus.rx_data !== 8'h66)
            begin errors++; $display("FAIL simul_empty got cnt=%0d rx=%h exp 1 66", bus.count, bus.rx_data); end
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 8'hC1, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.count !== 4'd0 || bus.data_ready !== 1'b0 || bus.rx_data !== 8'hFF || bus.overrun_error !== 1'b0)
            begin errors++; $display("FAIL midrst got cnt=%0d rdy=%b rx=%h ovr=%b exp 0 0 ff 0",
                                     bus.count, bus.data_ready, bus.rx_data, bus.overrun_error); end
        q.delete();
        ovr_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 8'h3C, 1'b0);
        checks++; if (bus.rx_data !== 8'h3C || bus.count !== 4'd1)
            begin errors++; $display("FAIL midrst_first got rx=%h cnt=%0d exp 3c 1", bus.rx_data, bus.count); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic ld, rd;
            if ((n / 100) % 2 == 0) begin
                ld = ($urandom_range(0, 3) != 0);
                rd = ($urandom_range(0, 3) == 0);
            end else begin
                ld = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 3) != 0);
            end
            cycle(ld, 8'($urandom), rd);
            checks++;
            if (bus.rx_data !== exp_rx() || bus.count !== 4'(q.size()) ||
                bus.data_ready !== (q.size() > 0) || bus.overrun_error !== ovr_m) begin
                errors++;
                $display("FAIL random_%0d got rx=%h cnt=%0d rdy=%b ovr=%b exp %h %0d %b %b", n,
                         bus.rx_data, bus.count, bus.data_ready, bus.overrun_error,
                         exp_rx(), q.size(), (q.size() > 0), ovr_m);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_wrap();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_fifo.md
# rx_fifo

Receive-side byte buffer for the UART receiver, sitting directly downstream of the receiver control unit. It captures each good packet's data byte on the controller's `load_buffer` strobe and holds bytes in first-in, first-out order. It presents the oldest byte to the host with a `data_ready` / `data_read` handshake, and reports bytes lost to overflow through a sticky `overrun_error` flag.

## Interface
Parameters:
- `DEPTH`, 8, number of byte entries; power of two, ≥ 2
- `DATA_W`, 8, bits per entry

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `load_buffer`  in  1  one-cycle strobe from the receiver controller: push `packet_data`
- `packet_data`  in  DATA_W  assembled packet byte, valid when `load_buffer` = 1
- `data_read`  in  1  host pop strobe; sampled every cycle
- `rx_data`  out  DATA_W  oldest stored byte (show-ahead); all-ones when empty
- `data_ready`  out  1  FIFO non-empty
- `overrun_error`  out  1  sticky flag: a byte was dropped because the FIFO was full
- `count`  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH

## Operation
- Push: occurs when `load_buffer`=1 and (count<DEPTH, or a pop occurs in the same cycle).
  - `packet_data` is written at the write pointer.
  - The write pointer then advances.
- Pop: occurs when `data_read`=1 and `data_ready`=1.
  - The read pointer advances.
  - `data_read` while empty is ignored; no pointer or count change.
- Pointers: `$clog2(DEPTH)` bits each, wrap modulo DEPTH.
  - Full and empty are decided from `count`, never from pointer equality.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - When empty: push only (the pop is ignored); count becomes 1.
  - When full: both proceed; the oldest byte leaves, the new byte enters; count stays DEPTH; no overrun.
- Overrun:
  - `load_buffer`=1 with count=DEPTH and no pop → the byte is discarded; the stored contents are unchanged.
  - On that condition `overrun_error` is set.
  - `overrun_error` is cleared on any edge where `data_read`=1, whether or not a pop occurs.
  - Set and clear are mutually exclusive by construction, because a read while full is a pop.
- `rx_data` = mem[rd_ptr] when count>0, else `{DATA_W{1'b1}}`.
- Memory contents are not reset; only the pointers, `count` and the flag are reset.

## Timing
- Reset (async, immediate) forces:
  - `count`=0, `data_ready`=0, `overrun_error`=0, `rx_data`=all-ones
  - read pointer = write pointer = 0
- Push latency: a byte strobed at edge k is visible on `rx_data` with `data_ready`=1 in the cycle after edge k.
- Pop latency: `data_read` sampled at edge k; the next byte (or all-ones) is shown after edge k.
- Back-to-back strobes: `load_buffer` may assert every cycle and `data_read` may assert every cycle; full throughput, no bubbles.
- `rst` asserted mid-stream discards all stored bytes; the first push after release is the next byte output.
- All outputs are combinational from registers only; there is no input-to-output combinational path.

## Structure
- Package `rx_pkg`:
  - `RX_DATA_W` = 8
  - `RX_IDLE_BYTE` = all-ones constant
  - `RX_FIFO_DEPTH` default
- Sub-module `fifo_ptr`:
  - A wrapping pointer counter with `clk`, `rst`, `inc`, `ptr`, parameterised by width.
  - Two instances: read pointer and write pointer.
- Top level holds the storage array, the count register, the overrun flag and the push/pop qualification logic.

## Test plan
- Reset then idle:
  - `rst` pulse → `count`=0, `data_ready`=0, `rx_data`=8'hFF, `overrun_error`=0.
  - A `data_read` pulse while empty changes nothing.
- Single byte:
  - Push 8'hA5 → the next cycle shows `rx_data`=8'hA5, `data_ready`=1, `count`=1.
  - `data_read` → `data_ready`=0, `rx_data`=8'hFF.
- Ordering and wrap:
  - Push 8'h01..8'h08 (fills DEPTH=8), pop all, then push and pop 8'h09..8'h0C.
  - Bytes must come out in push order across the pointer wrap; `count` tracks 8 down to 0.
- Overrun:
  - Fill with 8'h10..8'h17, then push 8'h99 → `overrun_error`=1, `count`=8.
  - Pops return 8'h10..8'h17; 8'h99 never appears.
  - The first `data_read` clears the flag.
- Simultaneous events:
  - Full, with `load_buffer`+`data_read` in the same cycle, pushing 8'h55 → `overrun_error` stays 0, `count` stays 8, 8'h55 is the last byte out.
  - Empty, with both strobes pushing 8'h66 → `count`=1, `rx_data`=8'h66.
- Reset mid-stream:
  - Three bytes stored, then assert `rst` asynchronously between edges → outputs reset immediately.
  - The next push of 8'h3C is the first byte out.
